sha512_unit: RTL and testbench

Packet-processing unit sitting between the packet-communication arbiter and the result path. It accepts byte-wide internal packets, stores each data packet in the memory of the first idle thread and runs a shared round engine over loaded threads in load order. For each completed thread it pushes a fixed 8-word result record into an output buffer (UOB). Init packets select the program entry point. The SHA-512 datapath is outside this block's scope; the round engine is a countdown of `cnt` cycles per thread.

---
 rtl/sha512_unit.sv | 264 ++++++++++++++++++++++++++
 tb/tb_sha512_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sha512_unit.sv
// Packet intake, per-thread memories, a shared countdown round engine and a result FIFO (UOB).
// Data packets load the lowest idle thread; threads run in load order and emit 8-word records.
module sha512_unit #(
  parameter int unsigned N_CORES          = 4,
  parameter int unsigned UNIT_INPUT_WIDTH = 8
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [UNIT_INPUT_WIDTH-1:0] unit_in,
  input  logic                        unit_in_ctrl,
  input  logic                        unit_in_wr_en,
  output logic                        unit_in_afull,
  output logic                        unit_in_ready,
  output logic [15:0]                 dout,
  input  logic                        rd_en,
  output logic                        empty
);
  localparam int unsigned TW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int unsigned IW = UNIT_INPUT_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StSkip} pstate_e;
  typedef enum logic [2:0] {ThIdle, ThLoading, ThLoaded, ThRunning, ThOutput} tstate_e;
  typedef enum logic [1:0] {EngIdle, EngRun, EngOut} estate_e;

  // Input FIFO
  logic [IW-1:0] ifq_mem [32];
  logic [4:0]    ifq_wp_q, ifq_rp_q;
  logic [5:0]    ifq_cnt_q;
  logic          ifq_wr, ifq_rd, ifq_empty, ifq_full;
  logic [7:0]    head_byte;
  logic          head_ctrl;

  assign ifq_empty     = (ifq_cnt_q == 6'd0);
  assign ifq_full      = (ifq_cnt_q == 6'd32);
  assign ifq_wr        = unit_in_wr_en && !ifq_full;
  assign head_byte     = ifq_mem[ifq_rp_q][7:0];
  assign head_ctrl     = ifq_mem[ifq_rp_q][IW-1];
  assign unit_in_afull = (ifq_cnt_q >= 6'd28);

  always_ff @(posedge CLK) begin
    if (ifq_wr) ifq_mem[ifq_wp_q] <= {unit_in_ctrl, unit_in};
  end

  // Parser and thread state
  pstate_e       pstate_q, pstate_d;
  tstate_e       tstate_q [N_CORES];
  tstate_e       tstate_d [N_CORES];
  logic [4:0]    th_entry_q [N_CORES];
  logic [4:0]    th_entry_d [N_CORES];
  logic [TW-1:0] cur_q, cur_d;
  logic [7:0]    bcnt_q, bcnt_d;
  logic [23:0]   wbuf_q, wbuf_d;
  logic [4:0]    entry_q, entry_d;
  logic          any_idle;
  logic [TW-1:0] sel_idle;

  // Thread memories
  logic [31:0]   tmem [N_CORES*32];
  logic          mem_we;
  logic [TW+4:0] mem_waddr;
  logic [31:0]   mem_wdata;

  always_ff @(posedge CLK) begin
    if (mem_we) tmem[mem_waddr] <= mem_wdata;
  end

  // Load-order queue
  logic [TW-1:0] lq_mem [N_CORES];
  logic [TW-1:0] lq_wp_q, lq_rp_q, lq_head;
  logic [TW:0]   lq_cnt_q;
  logic          lq_push, lq_pop;

  assign lq_head = lq_mem[lq_rp_q];

  always_ff @(posedge CLK) begin
    if (lq_push) lq_mem[lq_wp_q] <= cur_q;
  end

  // Round engine and record formatting
  estate_e       estate_q, estate_d;
  logic [TW-1:0] eng_thr_q, eng_thr_d;
  logic [31:0]   run_q, run_d;
  logic [2:0]    wcnt_q, wcnt_d;
  logic [31:0]   start_cnt;
  logic [127:0]  rec;

  assign start_cnt = tmem[{lq_head, 5'd0}];
  assign rec = {8'h00, 3'b000, th_entry_q[eng_thr_q], tmem[{eng_thr_q, 5'd8}][7:0],
                tmem[{eng_thr_q, 5'd1}][7:0], tmem[{eng_thr_q, 5'd0}],
                tmem[{eng_thr_q, 5'd7}], tmem[{eng_thr_q, 5'd6}]};

  // Output buffer (UOB), first-word-fall-through
  logic [15:0] uob_mem [32];
  logic [4:0]  uob_wp_q, uob_rp_q;
  logic [5:0]  uob_cnt_q;
  logic        uob_wr, uob_rd;
  logic [15:0] uob_wdata;

  assign empty  = (uob_cnt_q == 6'd0);
  assign dout   = empty ? 16'h0000 : uob_mem[uob_rp_q];
  assign uob_rd = rd_en && !empty;

  always_ff @(posedge CLK) begin
    if (uob_wr) uob_mem[uob_wp_q] <= uob_wdata;
  end

  always_comb begin
    any_idle = 1'b0;
    sel_idle = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (tstate_q[i] == ThIdle) begin
        any_idle = 1'b1;
        sel_idle = TW'(i);
      end
    end
  end

  assign unit_in_ready = any_idle && (pstate_q == StIdle) && ifq_empty;

  always_comb begin
    pstate_d   = pstate_q;
    tstate_d   = tstate_q;
    th_entry_d = th_entry_q;
    cur_d      = cur_q;
    bcnt_d     = bcnt_q;
    wbuf_d     = wbuf_q;
    entry_d    = entry_q;
    ifq_rd     = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = {cur_q, bcnt_q[6:2]};
    mem_wdata  = {head_byte, wbuf_q};
    lq_push    = 1'b0;
    lq_pop     = 1'b0;
    estate_d   = estate_q;
    eng_thr_d  = eng_thr_q;
    run_d      = run_q;
    wcnt_d     = wcnt_q;
    uob_wr     = 1'b0;
    uob_wdata  = rec[{wcnt_q, 4'b0000} +: 16];

    if (!ifq_empty) begin
      unique case (pstate_q)
        StIdle: begin
          if (!head_ctrl) begin
            ifq_rd = 1'b1;  // stray payload outside a packet
          end else if (head_byte[2:0] == 3'b000) begin
            // Data header stays at the FIFO head until a thread frees up
            if (any_idle) begin
              ifq_rd             = 1'b1;
              cur_d              = sel_idle;
              tstate_d[sel_idle] = ThLoading;
              bcnt_d             = 8'd0;
              pstate_d           = StLoad;
            end
          end else begin
            ifq_rd = 1'b1;
            if (head_byte[2:0] == 3'b001) entry_d = head_byte[7:3];
            pstate_d = StSkip;
          end
        end
        StLoad: begin
          ifq_rd = 1'b1;
          if (head_ctrl) begin
            tstate_d[cur_q]   = ThLoaded;
            th_entry_d[cur_q] = entry_q;
            lq_push           = 1'b1;
            pstate_d          = StIdle;
          end else if (!bcnt_q[7]) begin
            bcnt_d = bcnt_q + 8'd1;
            wbuf_d = {head_byte, wbuf_q[23:8]};
            mem_we = (bcnt_q[1:0] == 2'd3);
          end
        end
        StSkip: begin
          ifq_rd = 1'b1;
          if (head_ctrl) pstate_d = StIdle;
        end
        default: pstate_d = StIdle;
      endcase
    end

    unique case (estate_q)
      EngIdle: begin
        if (lq_cnt_q != '0) begin
          lq_pop            = 1'b1;
          eng_thr_d         = lq_head;
          tstate_d[lq_head] = ThRunning;
          run_d             = (start_cnt == 32'd0) ? 32'd1 : start_cnt;
          estate_d          = EngRun;
        end
      end
      EngRun: begin
        if (run_q == 32'd1) begin
          tstate_d[eng_thr_q] = ThOutput;
          wcnt_d              = 3'd0;
          estate_d            = EngOut;
        end else begin
          run_d = run_q - 32'd1;
        end
      end
      EngOut: begin
        // Room for the whole record is reserved before the first word goes out
        if (wcnt_q != 3'd0 || uob_cnt_q <= 6'd24) begin
          uob_wr = 1'b1;
          wcnt_d = wcnt_q + 3'd1;
          if (wcnt_q == 3'd7) begin
            tstate_d[eng_thr_q] = ThIdle;
            estate_d            = EngIdle;
          end
        end
      end
      default: estate_d = EngIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ifq_wp_q  <= '0;
      ifq_rp_q  <= '0;
      ifq_cnt_q <= '0;
      pstate_q  <= StIdle;
      for (int i = 0; i < N_CORES; i++) begin
        tstate_q[i]   <= ThIdle;
        th_entry_q[i] <= '0;
      end
      cur_q     <= '0;
      bcnt_q    <= '0;
      wbuf_q    <= '0;
      entry_q   <= '0;
      lq_wp_q   <= '0;
      lq_rp_q   <= '0;
      lq_cnt_q  <= '0;
      estate_q  <= EngIdle;
      eng_thr_q <= '0;
      run_q     <= '0;
      wcnt_q    <= '0;
      uob_wp_q  <= '0;
      uob_rp_q  <= '0;
      uob_cnt_q <= '0;
    end else begin
      if (ifq_wr) ifq_wp_q <= ifq_wp_q + 5'd1;
      if (ifq_rd) ifq_rp_q <= ifq_rp_q + 5'd1;
      ifq_cnt_q  <= ifq_cnt_q + {5'd0, ifq_wr} - {5'd0, ifq_rd};
      pstate_q   <= pstate_d;
      tstate_q   <= tstate_d;
      th_entry_q <= th_entry_d;
      cur_q      <= cur_d;
      bcnt_q     <= bcnt_d;
      wbuf_q     <= wbuf_d;
      entry_q    <= entry_d;
      if (lq_push) lq_wp_q <= (lq_wp_q == TW'(N_CORES - 1)) ? '0 : lq_wp_q + 1'b1;
      if (lq_pop)  lq_rp_q <= (lq_rp_q == TW'(N_CORES - 1)) ? '0 : lq_rp_q + 1'b1;
      lq_cnt_q   <= lq_cnt_q + {{TW{1'b0}}, lq_push} - {{TW{1'b0}}, lq_pop};
      estate_q   <= estate_d;
      eng_thr_q  <= eng_thr_d;
      run_q      <= run_d;
      wcnt_q     <= wcnt_d;
      if (uob_wr) uob_wp_q <= uob_wp_q + 5'd1;
      if (uob_rd) uob_rp_q <= uob_rp_q + 5'd1;
      uob_cnt_q  <= uob_cnt_q + {5'd0, uob_wr} - {5'd0, uob_rd};
    end
  end

endmodule

// File: tb/tb_sha512_unit.sv
// Directed bench for sha512_unit: packet loading, record contents, stalls, discard and reset.
module tb_sha512_unit;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  unit_in = 8'h00;
  logic        unit_in_ctrl = 1'b0;
  logic        unit_in_wr_en = 1'b0;
  logic        unit_in_afull;
  logic        unit_in_ready;
  logic [15:0] dout;
  logic        rd_en = 1'b0;
  logic        empty;

  int          n_vec = 0;
  int          n_miss = 0;
  logic        saw_afull = 1'b0;
  logic [7:0]  pl [136];
  int          lat;

  sha512_unit #(.N_CORES(4), .UNIT_INPUT_WIDTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .unit_in(unit_in), .unit_in_ctrl(unit_in_ctrl),
    .unit_in_wr_en(unit_in_wr_en), .unit_in_afull(unit_in_afull),
    .unit_in_ready(unit_in_ready), .dout(dout), .rd_en(rd_en), .empty(empty)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] b, input logic c);
    int t = 0;
    while (unit_in_afull && t < 20000) begin
      saw_afull = 1'b1;
      @(negedge CLK);
      t++;
    end
    if (t >= 20000) check_val("afull_wait", {31'd0, unit_in_afull}, 32'd0);
    unit_in = b; unit_in_ctrl = c; unit_in_wr_en = 1'b1;
    @(negedge CLK);
    unit_in_wr_en = 1'b0; unit_in_ctrl = 1'b0;
  endtask

  task automatic build(input logic [31:0] cnt, input logic [7:0] id, input logic [7:0] sl,
                       input logic [7:0] kl, input string salt, input string key);
    for (int i = 0; i < 136; i++) pl[i] = 8'hA5 ^ 8'(i);
    for (int i = 0; i < 4; i++) pl[i] = cnt[8*i +: 8];
    pl[4] = sl; pl[5] = 8'h00; pl[6] = 8'h00; pl[7] = 8'h00;
    for (int i = 0; i < 16; i++) pl[8+i] = (i < salt.len()) ? salt[i] : 8'h00;
    for (int i = 0; i < 8; i++) pl[24+i] = id;
    pl[32] = kl;
    for (int i = 33; i < 40; i++) pl[i] = 8'h00;
    for (int i = 0; i < 64; i++) pl[40+i] = (i < key.len()) ? key[i] : 8'h00;
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int len);
    put(hdr, 1'b1);
    for (int i = 0; i < len; i++) put(pl[i], 1'b0);
    put(8'h00, 1'b1);
  endtask

  task automatic wait_out(input int budget, output int cycles);
    cycles = 0;
    while (empty && cycles < budget) begin
      @(negedge CLK);
      cycles++;
    end
  endtask

  task automatic read_rec(input string tag, input logic [7:0] id, input logic [31:0] cnt,
                          input logic [7:0] sl, input logic [7:0] kl, input logic [4:0] ent);
    logic [15:0] exp [8];
    int t;
    for (int k = 0; k < 4; k++) exp[k] = {id, id};
    exp[4] = cnt[15:0]; exp[5] = cnt[31:16]; exp[6] = {kl, sl}; exp[7] = {8'h00, 3'b000, ent};
    for (int k = 0; k < 8; k++) begin
      wait_out(30000, t);
      if (empty) begin
        check_val($sformatf("%s_timeout", tag), {31'd0, empty}, 32'd0);
        return;
      end
      check_val($sformatf("%s_w%0d", tag, k), {16'd0, dout}, {16'd0, exp[k]});
      rd_en = 1'b1;
      @(negedge CLK);
      rd_en = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check_val("rst_ready", {31'd0, unit_in_ready}, 32'd1);
    check_val("rst_empty", {31'd0, empty}, 32'd1);
    check_val("rst_afull", {31'd0, unit_in_afull}, 32'd0);
    check_val("rst_dout", {16'd0, dout}, 32'd0);

    rd_en = 1'b1;
    @(negedge CLK);
    rd_en = 1'b0;
    check_val("rd_empty_empty", {31'd0, empty}, 32'd1);
    check_val("rd_empty_dout", {16'd0, dout}, 32'd0);

    // Init packet: entry = 1
    put(8'h09, 1'b1);
    put(8'h00, 1'b1);
    repeat (5) @(negedge CLK);
    check_val("init_empty", {31'd0, empty}, 32'd1);
    check_val("init_ready", {31'd0, unit_in_ready}, 32'd1);

    // Main vector
    build(32'd16384, 8'h0f, 8'd8, 8'd8, "FURCPa.k", "password");
    send_pkt(8'h00, 104);
    wait_out(20000, lat);
    check_val("main_latency", {31'd0, (lat >= 16384 && lat <= 16400)}, 32'd1);
    read_rec("main", 8'h0f, 32'h0000_4000, 8'h08, 8'h08, 5'd1);
    check_val("main_ready", {31'd0, unit_in_ready}, 32'd1);

    // cnt = 0 runs for one engine cycle
    build(32'd0, 8'h33, 8'd3, 8'd5, "", "");
    send_pkt(8'h00, 40);
    wait_out(200, lat);
    check_val("cnt0_latency", {31'd0, lat <= 20}, 32'd1);
    read_rec("cnt0", 8'h33, 32'd0, 8'd3, 8'd5, 5'd1);

    // Unknown type is discarded
    build(32'd1, 8'h99, 8'd1, 8'd1, "", "");
    send_pkt(8'h02, 40);
    repeat (60) @(negedge CLK);
    check_val("disc_empty", {31'd0, empty}, 32'd1);
    check_val("disc_ready", {31'd0, unit_in_ready}, 32'd1);

    // entry = 3, then five packets against four threads
    put(8'h19, 1'b1);
    put(8'h00, 1'b1);
    for (int p = 0; p < 4; p++) begin
      build(32'd5000, 8'h41 + 8'(p), 8'(p + 1), 8'(16 + p), "", "");
      send_pkt(8'h00, 40);
    end
    repeat (5) @(negedge CLK);
    check_val("four_ready", {31'd0, unit_in_ready}, 32'd0);
    saw_afull = 1'b0;
    build(32'd5000, 8'h45, 8'd5, 8'd20, "", "");
    send_pkt(8'h00, 40);
    check_val("fifth_afull", {31'd0, saw_afull}, 32'd1);
    for (int p = 0; p < 5; p++) begin
      read_rec($sformatf("five%0d", p), 8'h41 + 8'(p), 32'd5000, 8'(p + 1), 8'(16 + p), 5'd3);
    end

    // Oversized payload: only the first 128 bytes are kept
    build(32'd7, 8'h77, 8'h12, 8'h34, "", "");
    send_pkt(8'h00, 130);
    read_rec("long", 8'h77, 32'd7, 8'h12, 8'h34, 5'd3);
    repeat (3) @(negedge CLK);
    check_val("long_ready", {31'd0, unit_in_ready}, 32'd1);

    // Reset while a thread is running loses it
    build(32'd3000, 8'h55, 8'd1, 8'd1, "", "");
    send_pkt(8'h00, 40);
    repeat (100) @(negedge CLK);
    RESET = 1'b1;
    #1;
    check_val("mrst_empty", {31'd0, empty}, 32'd1);
    check_val("mrst_ready", {31'd0, unit_in_ready}, 32'd1);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (3500) @(negedge CLK);
    check_val("mrst_no_rec", {31'd0, empty}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
